// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the multicycle MIPS datapath: ALUOp/funct decode,
// single-cycle ALU ops and an iterative shift-add MULTU writing HI/LO.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned AW  = 2 * WIDTH;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] mcand, mplier;
    logic [AW-1:0]    acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] dec_res;
    logic             dec_ill, dec_mul;
    logic [SHW-1:0]   sh;
    logic             slt_s, slt_u;
    logic             accept, last;
    logic [AW-1:0]    addend, acc_sum;

    assign in_ready = (state == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign sh       = a[SHW-1:0];
    assign slt_s    = $signed(a) < $signed(b);
    assign slt_u    = a < b;

    // Operation decode; illegal ops leave dec_res at zero.
    always_comb begin
        dec_res = '0;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        case (alu_op)
            3'b000: begin
                case (funct)
                    6'h20:   dec_res = a + b;
                    6'h22:   dec_res = a - b;
                    6'h24:   dec_res = a & b;
                    6'h25:   dec_res = a | b;
                    6'h26:   dec_res = a ^ b;
                    6'h27:   dec_res = ~(a | b);
                    6'h2A:   dec_res = WIDTH'(slt_s);
                    6'h2B:   dec_res = WIDTH'(slt_u);
                    6'h04:   dec_res = b << sh;
                    6'h06:   dec_res = b >> sh;
                    6'h07:   dec_res = WIDTH'($signed(b) >>> sh);
                    6'h10:   dec_res = hi;
                    6'h12:   dec_res = lo;
                    6'h19:   dec_mul = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            3'b001:  dec_res = a - b;
            3'b010:  dec_res = a + b;
            3'b011:  dec_res = a + b;
            3'b100:  dec_res = a & b;
            3'b101:  dec_res = a | b;
            3'b110:  dec_res = WIDTH'(slt_s);
            default: dec_ill = 1'b1;
        endcase
    end

    // One shift-add step per MUL cycle.
    assign addend  = mplier[0] ? (AW'(mcand) << cnt) : '0;
    assign acc_sum = acc + addend;
    assign last    = (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept && dec_mul) state_d = MUL;
            MUL:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_mul) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= dec_res;
                            zero      <= (dec_res == '0);
                            illegal   <= dec_ill;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_sum;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (last) begin
                        hi        <= acc_sum[AW-1:WIDTH];
                        lo        <= acc_sum[WIDTH-1:0];
                        result    <= '0;
                        zero      <= 1'b1;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected {result,zero,illegal} queued on
// accept and checked against each out_valid pulse.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic [W-1:0]  result;
    logic          zero, illegal;

    logic [W+1:0]  exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            logic [W+1:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out_valid got result=%h zero=%b illegal=%b, none expected",
                         result, zero, illegal);
            end else begin
                e = exp_q.pop_front();
                if ({result, zero, illegal} !== e) begin
                    n_err++;
                    $display("FAIL scoreboard got result=%h zero=%b illegal=%b, want result=%h zero=%b illegal=%b",
                             result, zero, illegal, e[W+1:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [5:0] fn,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eres, input logic eill);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_ready in_ready=%b after %0d cycles, want 1", in_ready, t);
        end
        in_valid = 1'b1; alu_op = op; funct = fn; a = va; b = vb;
        @(posedge clk);
        exp_q.push_back({eres, (eres == '0), eill});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s pending=%0d, want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, result, zero, illegal} !== {2'b00, 32'h0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_state got rdy=%b ov=%b res=%h z=%b ill=%b, want 0 0 0 0 0",
                     in_ready, out_valid, result, zero, illegal);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send(3'b000, 6'h20, 32'd5, 32'd7, 32'd12, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL add_latency out_valid=%b want 1", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse out_valid=%b want 0", out_valid);
        end
        send(3'b001, 6'h00, 32'd5, 32'd5, 32'd0, 1'b0);
        drain("basic");
    endtask

    task automatic test_cmp_shift();
        send(3'b000, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        send(3'b000, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        send(3'b000, 6'h07, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0);
        send(3'b000, 6'h06, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0);
        send(3'b000, 6'h04, 32'd31, 32'd1, 32'h8000_0000, 1'b0);
        send(3'b000, 6'h27, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 1'b0);
        drain("cmp_shift");
    endtask

    task automatic test_immediate();
        send(3'b101, 6'h00, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        send(3'b110, 6'h00, 32'hFFFF_FFFD, 32'd2, 32'd1, 1'b0);
        send(3'b100, 6'h00, 32'hFF, 32'h0F, 32'h0F, 1'b0);
        drain("immediate");
    endtask

    task automatic test_multu();
        int busy = 0;
        send(3'b000, 6'h19, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
        // hold an ADD on the inputs while busy; it must not be taken
        in_valid = 1'b1; alu_op = 3'b000; funct = 6'h20; a = 32'd1; b = 32'd1;
        @(negedge clk);
        while (!in_ready && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy != 32) begin
            n_err++;
            $display("FAIL multu_busy got %0d cycles want 32", busy);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL multu_done_with_ready out_valid=%b want 1", out_valid);
        end
        // MFHI accepted at the first edge after completion
        funct = 6'h10;
        @(posedge clk);
        exp_q.push_back({32'h0000_0001, 1'b0, 1'b0});
        #1 in_valid = 1'b0;
        send(3'b000, 6'h12, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0);
        drain("multu");
    endtask

    task automatic test_illegal();
        send(3'b000, 6'h3F, 32'd9, 32'd9, 32'd0, 1'b1);
        send(3'b111, 6'h20, 32'd9, 32'd9, 32'd0, 1'b1);
        send(3'b000, 6'h10, 32'd0, 32'd0, 32'h0000_0001, 1'b0);
        send(3'b000, 6'h12, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0);
        drain("illegal");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        for (int i = 0; i < 8; i++) begin
            x = $urandom; y = $urandom;
            case (i % 3)
                0:       send(3'b010, 6'h00, x, y, x + y, 1'b0);
                1:       send(3'b000, 6'h26, x, y, x ^ y, 1'b0);
                default: send(3'b000, 6'h22, x, y, x - y, 1'b0);
            endcase
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid_mul();
        send(3'b000, 6'h19, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_mul_reset cyc%0d rdy=%b ov=%b want 0 0", i, in_ready, out_valid);
            end
        end
        rst_n = 1'b1;
        send(3'b000, 6'h10, 32'd0, 32'd0, 32'd0, 1'b0);
        send(3'b000, 6'h12, 32'd0, 32'd0, 32'd0, 1'b0);
        send(3'b000, 6'h20, 32'd1, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL add_after_reset out_valid=%b want 1", out_valid);
        end
        drain("mid_mul");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cmp_shift();
        test_immediate();
        test_multu();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the multicycle MIPS datapath. It merges ALU-control decoding (ALUOp/funct) with the datapath operations and adds unsigned shifts, SLTU, ORI and SLTI support. It also adds an iterative shift-add MULTU unit with HI/LO registers. It sits between the register-read stage and writeback, using a valid/ready input handshake and a registered result.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8. SHW = $clog2(WIDTH).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; = (state==IDLE) && rst_n.
- alu_op  in  3  main-control ALUOp.
- funct  in  6  instruction[5:0], used only when alu_op==3'b000.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate).
- out_valid  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered result; holds between pulses.
- zero  out  1  registered (result==0), updated with result.
- illegal  out  1  registered; 1 if the accepted op did not decode.

## Operation
- Accept: in_valid && in_ready at a rising edge. Inputs are sampled only on accept.
- Decode for alu_op==000, by funct:
  - 0x20 ADD; 0x22 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x2A SLT (signed); 0x2B SLTU (unsigned).
  - 0x04 SLLV: b << a[SHW-1:0].
  - 0x06 SRLV: logical right shift of b by a[SHW-1:0].
  - 0x07 SRAV: arithmetic right shift of b by a[SHW-1:0].
  - 0x10 MFHI: result = HI. 0x12 MFLO: result = LO.
  - 0x19 MULTU: multicycle; {HI,LO} = a*b, unsigned, 2*WIDTH bits.
  - Any other funct: illegal.
- Decode for other alu_op values:
  - 001 SUB (branches); 010 ADD (LW/SW/LUI); 011 ADD (ADDI); 100 AND (ANDI).
  - 101 OR (ORI); 110 SLT signed (SLTI); 111 illegal.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow trap. SLT/SLTU give {WIDTH-1 zeros, bit}.
- Illegal op: result=0, zero=1, illegal=1, out_valid pulses. HI/LO are unchanged.
- FSM states:
  - IDLE→IDLE on accept of a single-cycle op.
  - IDLE→MUL on accept of MULTU. Load mcand=a, mplier=b, acc=0, cnt=0.
  - MUL: each cycle, if mplier[0] then acc += mcand << cnt (2*WIDTH-bit acc); then mplier >>= 1 and cnt++.
  - MUL→IDLE after the step with cnt==WIDTH-1. On that edge write HI=acc[2W-1:W] and LO=acc[W-1:0], and set result=0, zero=1, illegal=0, out_valid=1.
- Reset (rst_n low at an edge), including mid-MUL:
  - state=IDLE; HI=LO=0; result=0; zero=0; illegal=0; out_valid=0; cnt=0.
  - In-flight multiply is discarded.
  - in_ready=0 while rst_n is low.

## Timing
- Single-cycle op accepted at edge E: out_valid=1 with result, zero and illegal during the cycle after E. Back-to-back accepts give consecutive pulses.
- MULTU accepted at edge E:
  - in_ready=0 for WIDTH cycles.
  - HI/LO and out_valid update at edge E+WIDTH.
  - in_ready=1 in the same cycle as out_valid.
- Accept/write ordering:
  - MFHI/MFLO accepted at the first edge after completion (E+WIDTH+1) returns the new HI/LO.
  - An MFHI accepted before a MULTU completes is impossible (in_ready=0).
- out_valid is never high two cycles for one accept. With no accept, out_valid=0 next cycle.
- in_valid while in_ready=0 is ignored. There is no downstream backpressure.

## Test plan
- Reset then basic ops (WIDTH=32): ADD 5+7 → result=12, zero=0, out_valid one cycle after accept. SUB alu_op=001, 5-5 → 0, zero=1.
- Compare/shift: a=0xFFFFFFFF, b=1.
  - SLT → 1; SLTU → 0.
  - SRAV with a=4, b=0x80000000 → 0xF8000000. SRLV, same operands → 0x08000000. SLLV a=31, b=1 → 0x80000000.
- MULTU a=0xFFFFFFFF, b=2:
  - in_ready low exactly 32 cycles; out_valid at edge E+32.
  - Then MFHI → 0x00000001, MFLO → 0xFFFFFFFE.
  - in_valid held high during busy is not accepted.
- Immediate modes: alu_op=101 with 0xF0|0x0F → 0xFF. alu_op=110, a=-3, b=2 → 1. alu_op=100, 0xFF&0x0F → 0x0F.
- Illegal: funct=0x3F with alu_op=000, then alu_op=111 → illegal=1, result=0, out_valid pulses each time, HI/LO unchanged.
- Reset mid-multiply: rst_n low at cycle 10 of a MULTU → next cycle HI=LO=0, in_ready=0 until rst_n high, no out_valid. A fresh ADD afterwards completes in 1 cycle.
